// File: rtl/lib_vld_to_len.sv
// Thermometer lane-mask stream to per-packet length record.
// Decodes each beat's mask to a lane count, accumulates with saturation, and emits one record per packet.
module lib_vld_to_len #(
  parameter int VLD_WIDTH = 8,
  parameter int BIN_WDTH  = $clog2(VLD_WIDTH),
  parameter int LEN_WDTH  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [VLD_WIDTH-1:0] s_vld,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [LEN_WDTH-1:0] m_len,
  output logic [BIN_WDTH-1:0] m_last_bin,
  output logic                m_err
);

  localparam int CNT_W = BIN_WDTH + 1;
  localparam int SUM_W = ((LEN_WDTH > CNT_W) ? LEN_WDTH : CNT_W) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic                 accept;
  logic [BIN_WDTH-1:0]  bin;
  logic [CNT_W-1:0]     cnt;
  logic [VLD_WIDTH-1:0] thermo;
  logic                 mask_ok;
  logic                 beat_err;
  logic [SUM_W-1:0]     sum;
  logic                 ovf;
  logic [LEN_WDTH-1:0]  acc, acc_base, acc_next;
  logic                 err_acc, err_base;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  // Mask decode: highest set lane gives the index; legality is an exact thermometer match.
  always_comb begin
    bin    = '0;
    thermo = '0;
    for (int unsigned i = 0; i < VLD_WIDTH; i++) begin
      if (s_vld[i]) bin = BIN_WDTH'(i);
    end
    for (int unsigned i = 0; i < VLD_WIDTH; i++) begin
      thermo[i] = (BIN_WDTH'(i) <= bin);
    end
    cnt     = (|s_vld) ? (CNT_W'(bin) + CNT_W'(1)) : '0;
    mask_ok = (|s_vld) && (s_vld == thermo) && (s_last || (&s_vld));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = s_last ? IDLE : BUSY;
  end

  // State outputs: the running totals only count while a packet is open
  always_comb begin
    acc_base = '0;
    err_base = 1'b0;
    if (state == BUSY) begin
      acc_base = acc;
      err_base = err_acc;
    end
  end

  always_comb begin
    sum      = SUM_W'(acc_base) + SUM_W'(cnt);
    ovf      = (sum > SUM_W'({LEN_WDTH{1'b1}}));
    acc_next = ovf ? '1 : sum[LEN_WDTH-1:0];
    beat_err = !mask_ok || ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      err_acc <= 1'b0;
    end else if (accept) begin
      if (s_last) begin
        acc     <= '0;
        err_acc <= 1'b0;
      end else begin
        acc     <= acc_next;
        err_acc <= err_base || beat_err;
      end
    end
  end

  // A new record may overwrite one being handed off in the same cycle, so no bubble appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_len      <= '0;
      m_last_bin <= '0;
      m_err      <= 1'b0;
    end else if (accept && s_last) begin
      m_valid    <= 1'b1;
      m_len      <= acc_next;
      m_last_bin <= bin;
      m_err      <= err_base || beat_err;
    end else if (m_valid && m_ready) begin
      m_valid    <= 1'b0;
    end
  end

endmodule
